// File: rtl/cnt_pwm_gen.sv
// PWM generator driven by an external free-running wrap counter.
// Double-buffered duty (valid/ready) applied only at period boundaries; flags wraps and count breaks.
module cnt_pwm_gen #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             en,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_tick,
    output logic             seq_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt_prev;
    logic [CNT_W-1:0] r_duty_act;
    logic [CNT_W-1:0] r_pend;
    logic             r_pend_full;
    logic             r_pwm;
    logic             r_tick;
    logic             r_seq_err;

    logic [CNT_W-1:0] w_cnt_exp;
    logic [CNT_W-1:0] w_duty_eff;
    logic             w_wrap;
    logic             w_active;
    logic             w_xfer;
    logic             w_apply;
    logic             w_pwm_nxt;
    logic             w_tick_nxt;
    logic             w_seq_err_nxt;

    // A wrap is recognised from the sampled previous count, so it is seen in the cycle cnt_in returns to 0.
    assign w_wrap    = (r_cnt_prev == CNT_MAX) && (cnt_in == '0);
    assign w_cnt_exp = r_cnt_prev + CNT_W'(1);
    assign w_active  = (r_state == S_ARMED) || (r_state == S_RUN);

    // Ready is masked during reset so no transfer can be accepted into a slot being cleared.
    assign duty_ready = rst_n && !r_pend_full;
    assign w_xfer     = duty_valid && duty_ready;
    assign w_apply    = w_wrap && w_active && r_pend_full;

    // At the boundary the pending value is used immediately, so the first cycle of the period is not stale.
    assign w_duty_eff = (w_wrap && r_pend_full) ? r_pend : r_duty_act;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_pwm_nxt     = 1'b0;
        w_tick_nxt    = 1'b0;
        w_seq_err_nxt = r_seq_err;

        case (r_state)
            S_IDLE:  if (en) w_state_nxt = S_ARMED;
            S_ARMED: if (w_wrap) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
        if (!en) w_state_nxt = S_IDLE;

        w_pwm_nxt  = ((r_state == S_RUN) || ((r_state == S_ARMED) && w_wrap))
                     && en && (cnt_in < w_duty_eff);
        w_tick_nxt = w_wrap && en && w_active;

        if (!en)
            w_seq_err_nxt = 1'b0;
        else if ((r_state == S_RUN) && (cnt_in != w_cnt_exp))
            w_seq_err_nxt = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt_prev  <= '0;
            r_duty_act  <= '0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_pwm       <= 1'b0;
            r_tick      <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt_prev <= cnt_in;
            r_pwm      <= w_pwm_nxt;
            r_tick     <= w_tick_nxt;
            r_seq_err  <= w_seq_err_nxt;

            // Transfer and apply are exclusive: a transfer needs an empty slot, an apply a full one.
            if (w_xfer) begin
                r_pend      <= duty_in;
                r_pend_full <= 1'b1;
            end else if (w_apply) begin
                r_pend_full <= 1'b0;
            end
            if (w_apply)
                r_duty_act <= r_pend;
        end
    end

    assign pwm_out     = r_pwm;
    assign period_tick = r_tick;
    assign seq_err     = r_seq_err;

endmodule

// File: tb/tb_cnt_pwm_gen.sv
// Directed bench for cnt_pwm_gen: a reset/start-up vector table followed by
// hand-written period sequences covering duty reload, wrap-cycle transfer, sequence errors and reset.
module tb_cnt_pwm_gen;

    logic       clk;
    logic       rst_n;
    logic [3:0] cnt_in;
    logic       en;
    logic [3:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_tick;
    logic       seq_err;

    int n_vec  = 0;
    int n_miss = 0;
    int highs  = 0;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] cnt;
        logic [3:0] duty;
        logic       valid;
        logic       pwm;
        logic       tick;
        logic       err;
        logic       ready;
    } vec_t;

    vec_t vecs [8];

    cnt_pwm_gen #(.CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt_in      (cnt_in),
        .en          (en),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .seq_err     (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample all outputs 1 time unit after the rising edge.
    task automatic step(input logic r, input logic e, input logic [3:0] c, input logic [3:0] d,
                        input logic v, input logic ep, input logic et, input logic ee,
                        input logic er, input string name);
        @(negedge clk);
        rst_n      = r;
        en         = e;
        cnt_in     = c;
        duty_in    = d;
        duty_valid = v;
        @(posedge clk);
        #1;
        check({name, ".pwm"},   pwm_out,     ep);
        check({name, ".tick"},  period_tick, et);
        check({name, ".err"},   seq_err,     ee);
        check({name, ".ready"}, duty_ready,  er);
        if (pwm_out === 1'b1) highs++;
    endtask

    // Steady counting with en=1: after the edge that sampled cnt=k, pwm = (k < duty) and tick = (k == 0).
    task automatic run_range(input int lo, input int hi, input int d, input logic ee,
                             input logic er, input string name);
        for (int k = lo; k <= hi; k++)
            step(1'b1, 1'b1, 4'(k), 4'd0, 1'b0, (k < d), (k == 0), ee, er,
                 $sformatf("%s[%0d]", name, k));
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        cnt_in     = 4'd0;
        duty_in    = 4'd0;
        duty_valid = 1'b0;

        //            rst  en   cnt    duty   vld   pwm  tick err  rdy
        vecs[0] = '{1'b0, 1'b1, 4'd5,  4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 4'd6,  4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 4'd7,  4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 4'd12, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 4'd13, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 4'd14, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 4'd0,  4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset, release, duty 4 loaded while ARMED, first wrap enters RUN.
        for (int i = 0; i < 8; i++)
            step(vecs[i].rst_n, vecs[i].en, vecs[i].cnt, vecs[i].duty, vecs[i].valid,
                 vecs[i].pwm, vecs[i].tick, vecs[i].err, vecs[i].ready,
                 $sformatf("vec%0d", i));

        // Steady duty 4.
        run_range(1, 15, 4, 1'b0, 1'b1, "p1");
        highs = 0;
        run_range(0, 15, 4, 1'b0, 1'b1, "p2");
        check_int("p2_highs", highs, 4);

        // Duty 12 requested mid-period: current period keeps 4, next period uses 12.
        highs = 0;
        run_range(0, 6, 4, 1'b0, 1'b1, "p3a");
        step(1'b1, 1'b1, 4'd7, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "p3_load12");
        run_range(8, 15, 4, 1'b0, 1'b0, "p3b");
        check_int("p3_highs", highs, 4);
        highs = 0;
        run_range(0, 15, 12, 1'b0, 1'b1, "p4");
        check_int("p4_highs", highs, 12);

        // Transfer in the wrap cycle with the slot empty: old duty 12 this period, 2 from the next wrap.
        highs = 0;
        step(1'b1, 1'b1, 4'd0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "p5_wrapload");
        run_range(1, 15, 12, 1'b0, 1'b0, "p5");
        check_int("p5_highs", highs, 12);
        highs = 0;
        run_range(0, 15, 2, 1'b0, 1'b1, "p6");
        check_int("p6_highs", highs, 2);

        // Count jump 5->9 in RUN: sticky error, pwm keeps following raw cnt_in.
        run_range(0, 5, 2, 1'b0, 1'b1, "p7a");
        step(1'b1, 1'b1, 4'd9, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "p7_jump");
        run_range(10, 15, 2, 1'b1, 1'b1, "p7b");
        run_range(0, 0, 2, 1'b1, 1'b1, "p8");
        // en drop at cnt=1 where RUN at duty 2 would otherwise drive pwm high.
        step(1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "p8_en0");

        // IDLE: pending duty 15 accepted and held; re-enable at a wrap only reaches ARMED.
        step(1'b1, 1'b0, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "idle2");
        step(1'b1, 1'b0, 4'd3, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "idle_load15");
        for (int k = 4; k <= 15; k++)
            step(1'b1, 1'b0, 4'(k), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 $sformatf("idle[%0d]", k));
        step(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "arm_at_wrap");
        for (int k = 1; k <= 15; k++)
            step(1'b1, 1'b1, 4'(k), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 $sformatf("armed[%0d]", k));

        // Duty 15 period (15 of 16 high) with duty 0 queued at cnt=3.
        highs = 0;
        run_range(0, 2, 15, 1'b0, 1'b1, "p10a");
        step(1'b1, 1'b1, 4'd3, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "p10_load0");
        run_range(4, 15, 15, 1'b0, 1'b0, "p10b");
        check_int("p10_highs", highs, 15);

        // Duty 0 period, duty 15 queued for the next.
        highs = 0;
        run_range(0, 2, 0, 1'b0, 1'b1, "p11a");
        step(1'b1, 1'b1, 4'd3, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "p11_load15");
        run_range(4, 15, 0, 1'b0, 1'b0, "p11b");
        check_int("p11_highs", highs, 0);

        // Reset mid-period while pwm is high and duty 9 is pending; the pending value must be lost.
        run_range(0, 3, 15, 1'b0, 1'b1, "p12");
        step(1'b1, 1'b1, 4'd4, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "p12_load9");
        step(1'b0, 1'b1, 4'd5, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "p12_reset");
        step(1'b1, 1'b1, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "p12_release");
        for (int k = 7; k <= 15; k++)
            step(1'b1, 1'b1, 4'(k), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                 $sformatf("rearm[%0d]", k));
        highs = 0;
        run_range(0, 15, 0, 1'b0, 1'b1, "p13");
        check_int("p13_highs", highs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
